// File: rtl/varredor_matriz_leds.sv
// Column-multiplexed 5x7 LED matrix scanner with blanking gap and blinking cursor overlay.
// Outputs are registered and reflect the scan state and inputs sampled at the same edge.
module varredor_matriz_leds #(
    parameter int unsigned DIV_VARREDURA  = 50000,
    parameter int unsigned CICLOS_APAGADO = 16,
    parameter int unsigned DIV_PISCA      = 12500000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic [2:0] coordColuna,
    input  logic [2:0] coordLinha,
    input  logic [6:0] matriz0,
    input  logic [6:0] matriz1,
    input  logic [6:0] matriz2,
    input  logic [6:0] matriz3,
    input  logic [6:0] matriz4,
    output logic [4:0] colunas,
    output logic [6:0] linhas,
    output logic [2:0] coluna_atual,
    output logic       fim_quadro
);

    localparam int unsigned ContMax = (DIV_VARREDURA > CICLOS_APAGADO) ?
                                      DIV_VARREDURA - 1 : CICLOS_APAGADO - 1;
    localparam int unsigned CW = (ContMax > 0) ? $clog2(ContMax + 1) : 1;
    localparam int unsigned PW = (DIV_PISCA > 1) ? $clog2(DIV_PISCA) : 1;

    localparam logic [CW-1:0] FimAtivo   = CW'(DIV_VARREDURA - 1);
    localparam logic [CW-1:0] FimApagado = CW'(CICLOS_APAGADO - 1);
    localparam logic [PW-1:0] FimPisca   = PW'(DIV_PISCA - 1);

    typedef enum logic [0:0] {StAtivo, StApagado} estado_t;

    estado_t       estado_q, estado_d;
    logic [CW-1:0] cont_q, cont_d;
    logic [2:0]    col_q, col_d;
    logic [PW-1:0] pisca_q, pisca_d;
    logic          fase_q, fase_d;

    logic [4:0]    colunas_q, colunas_d;
    logic [6:0]    linhas_q, linhas_d;
    logic [2:0]    coluna_atual_q, coluna_atual_d;
    logic          fim_quadro_q, fim_quadro_d;

    logic [6:0]    matriz_col;
    logic          cursor_ok;
    logic [6:0]    cursor;

    // State register: scan FSM, counters and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q       <= StAtivo;
            cont_q         <= '0;
            col_q          <= 3'd0;
            pisca_q        <= '0;
            fase_q         <= 1'b1;
            colunas_q      <= 5'b11111;
            linhas_q       <= 7'b0000000;
            coluna_atual_q <= 3'd0;
            fim_quadro_q   <= 1'b0;
        end else begin
            estado_q       <= estado_d;
            cont_q         <= cont_d;
            col_q          <= col_d;
            pisca_q        <= pisca_d;
            fase_q         <= fase_d;
            colunas_q      <= colunas_d;
            linhas_q       <= linhas_d;
            coluna_atual_q <= coluna_atual_d;
            fim_quadro_q   <= fim_quadro_d;
        end
    end

    // Next-state logic.
    always_comb begin
        estado_d = estado_q;
        cont_d   = cont_q + CW'(1);
        col_d    = col_q;
        unique case (estado_q)
            StAtivo: begin
                if (cont_q == FimAtivo) begin
                    estado_d = StApagado;
                    cont_d   = '0;
                end
            end
            StApagado: begin
                if (cont_q == FimApagado) begin
                    estado_d = StAtivo;
                    cont_d   = '0;
                    col_d    = (col_q == 3'd4) ? 3'd0 : col_q + 3'd1;
                end
            end
            default: begin
                estado_d = StAtivo;
                cont_d   = '0;
            end
        endcase

        // Blink timebase runs free of the scan FSM and of enable.
        if (pisca_q == FimPisca) begin
            pisca_d = '0;
            fase_d  = ~fase_q;
        end else begin
            pisca_d = pisca_q + PW'(1);
            fase_d  = fase_q;
        end
    end

    // Output logic, registered one edge later.
    always_comb begin
        case (col_q)
            3'd0:    matriz_col = matriz0;
            3'd1:    matriz_col = matriz1;
            3'd2:    matriz_col = matriz2;
            3'd3:    matriz_col = matriz3;
            3'd4:    matriz_col = matriz4;
            default: matriz_col = 7'b0000000;
        endcase

        cursor_ok = fase_q && (coordColuna == col_q) && (coordColuna <= 3'd4) &&
                    (coordLinha <= 3'd6);
        cursor    = cursor_ok ? (7'd1 << coordLinha) : 7'b0000000;

        colunas_d = 5'b11111;
        linhas_d  = 7'b0000000;
        if ((estado_q == StAtivo) && enable) begin
            colunas_d = ~(5'd1 << col_q);
            linhas_d  = matriz_col | cursor;
        end

        coluna_atual_d = col_q;
        fim_quadro_d   = (estado_q == StApagado) && (cont_q == FimApagado) && (col_q == 3'd4);
    end

    assign colunas      = colunas_q;
    assign linhas       = linhas_q;
    assign coluna_atual = coluna_atual_q;
    assign fim_quadro   = fim_quadro_q;

endmodule
